// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among NREQ writeback sources.
// Registered write stage (one-cycle latency) plus a saturating contention counter.
module rf_wb_arbiter #(
    parameter int NREQ  = 3,
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int CW    = 16
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*AW-1:0]    req_addr_i,
    input  logic [NREQ*WIDTH-1:0] req_data_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic                  hold_i,
    output logic                  rf_we_o,
    output logic [AW-1:0]         rf_addr_o,
    output logic [WIDTH-1:0]      rf_data_o,
    output logic [CW-1:0]         contention_cnt_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    gnt_idx;
    logic             gnt_any;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_data;
    logic             multi_valid;
    int               idx;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        if (!rst_i && !hold_i) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                idx = int'(ptr_q) + i;
                if (idx >= NREQ) idx = idx - NREQ;
                if (req_valid_i[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = PW'(idx);
                end
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_ready_o[k] = gnt_any && (gnt_idx == PW'(k));
        end
    end

    assign sel_addr    = req_addr_i[gnt_idx*AW +: AW];
    assign sel_data    = req_data_i[gnt_idx*WIDTH +: WIDTH];
    assign multi_valid = ($countones(req_valid_i) > 1);

    always_ff @(posedge clk) begin
        if (rst_i) begin
            ptr_q            <= '0;
            rf_we_o          <= 1'b0;
            rf_addr_o        <= '0;
            rf_data_o        <= '0;
            contention_cnt_o <= '0;
        end else begin
            if (gnt_any) begin
                ptr_q     <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
                rf_addr_o <= sel_addr;
                rf_data_o <= sel_data;
                // Address 0 is consumed but never written.
                rf_we_o   <= (sel_addr != '0);
            end else begin
                rf_we_o   <= 1'b0;
            end
            if (multi_valid && (contention_cnt_o != '1)) begin
                contention_cnt_o <= contention_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a
// behavioural round-robin model; a second instance with CW=4 covers saturation.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_valid = '0;
    logic [14:0] req_addr = '0;
    logic [95:0] req_data = '0;
    logic        hold = 1'b0;
    logic [2:0]  req_ready, req_ready_s;
    logic        rf_we, rf_we_s;
    logic [4:0]  rf_addr, rf_addr_s;
    logic [31:0] rf_data, rf_data_s;
    logic [15:0] cnt;
    logic [3:0]  cnt_s;

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk(clk), .rst_i(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
        .req_data_i(req_data), .req_ready_o(req_ready), .hold_i(hold),
        .rf_we_o(rf_we), .rf_addr_o(rf_addr), .rf_data_o(rf_data),
        .contention_cnt_o(cnt)
    );

    rf_wb_arbiter #(.CW(4)) dut_s (
        .clk(clk), .rst_i(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
        .req_data_i(req_data), .req_ready_o(req_ready_s), .hold_i(hold),
        .rf_we_o(rf_we_s), .rf_addr_o(rf_addr_s), .rf_data_o(rf_data_s),
        .contention_cnt_o(cnt_s)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference state
    int          m_ptr = 0;
    logic        m_we = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    int          m_cnt = 0;
    int          m_cnt4 = 0;
    int          m_g;
    logic [2:0]  obs_rdy;

    // random sources
    logic        src_v [3];
    logic [4:0]  src_a [3];
    logic [31:0] src_d [3];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                         input logic h, input logic r);
        logic [2:0] er;
        int g;
        int k;
        @(negedge clk);
        req_valid = v; req_addr = a; req_data = d; hold = h; rst = r;
        #1;
        g = -1;
        if (!r && !h) begin
            for (int i = 0; i < 3; i++) begin
                k = (m_ptr + i) % 3;
                if (g < 0 && v[k]) g = k;
            end
        end
        er = (g >= 0) ? 3'(1 << g) : 3'b000;
        obs_rdy = req_ready;
        m_g = g;
        check_val("ready", {61'b0, req_ready}, {61'b0, er});
        check_val("ready_s", {61'b0, req_ready_s}, {61'b0, er});
        if (r) begin
            m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_cnt = 0; m_cnt4 = 0;
        end else begin
            if ($countones(v) >= 2) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (g >= 0) begin
                m_ptr  = (g + 1) % 3;
                m_addr = a[g*5 +: 5];
                m_data = d[g*32 +: 32];
                m_we   = (m_addr != 5'd0);
            end else begin
                m_we = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_val("rf_we", {63'b0, rf_we}, {63'b0, m_we});
        check_val("rf_addr", {59'b0, rf_addr}, {59'b0, m_addr});
        check_val("rf_data", {32'b0, rf_data}, {32'b0, m_data});
        check_val("cnt", {48'b0, cnt}, 64'(m_cnt));
        check_val("cnt_s", {60'b0, cnt_s}, 64'(m_cnt4));
        check_val("rf_we_s", {63'b0, rf_we_s}, {63'b0, m_we});
    endtask

    localparam logic [14:0] A123 = {5'd3, 5'd2, 5'd1};
    localparam logic [95:0] DABC = {32'h0000_000C, 32'h0000_000B, 32'h0000_000A};

    logic [2:0]  rv;
    logic [14:0] ra;
    logic [95:0] rd;
    logic        rh, rr;
    logic [2:0]  fair_exp;

    initial begin
        // reset with everything valid
        cycle(3'b111, A123, DABC, 1'b0, 1'b1);
        check_val("rst_ready", {61'b0, obs_rdy}, 64'd0);
        cycle(3'b111, A123, DABC, 1'b0, 1'b1);
        check_val("rst_we", {63'b0, rf_we}, 64'd0);
        check_val("rst_cnt", {48'b0, cnt}, 64'd0);
        cycle(3'b111, A123, DABC, 1'b0, 1'b0);
        check_val("first_grant", {61'b0, obs_rdy}, 64'b001);

        // single requester
        cycle(3'b000, A123, DABC, 1'b0, 1'b1);
        cycle(3'b010, {5'd0, 5'd7, 5'd0}, {32'h0, 32'hDEAD_BEEF, 32'h0}, 1'b0, 1'b0);
        check_val("single_ready", {61'b0, obs_rdy}, 64'b010);
        check_val("single_we", {63'b0, rf_we}, 64'd1);
        check_val("single_addr", {59'b0, rf_addr}, 64'd7);
        check_val("single_data", {32'b0, rf_data}, 64'hDEAD_BEEF);
        cycle(3'b000, A123, DABC, 1'b0, 1'b0);
        check_val("single_we_off", {63'b0, rf_we}, 64'd0);

        // fairness
        cycle(3'b000, A123, DABC, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle(3'b111, A123, DABC, 1'b0, 1'b0);
            fair_exp = 3'(1 << (i % 3));
            check_val("fair_grant", {61'b0, obs_rdy}, {61'b0, fair_exp});
            check_val("fair_we", {63'b0, rf_we}, 64'd1);
        end
        check_val("fair_cnt", {48'b0, cnt}, 64'd6);

        // address 0 from requester 2 is consumed and dropped
        cycle(3'b100, {5'd0, 5'd2, 5'd1}, {32'h55, 32'hB, 32'hA}, 1'b0, 1'b0);
        check_val("a0_ready", {61'b0, obs_rdy}, 64'b100);
        check_val("a0_we", {63'b0, rf_we}, 64'd0);
        cycle(3'b111, A123, DABC, 1'b0, 1'b0);
        check_val("a0_ptr_wrap", {61'b0, obs_rdy}, 64'b001);

        // hold
        cycle(3'b000, A123, DABC, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(3'b101, A123, DABC, 1'b1, 1'b0);
            check_val("hold_ready", {61'b0, obs_rdy}, 64'd0);
        end
        check_val("hold_cnt", {48'b0, cnt}, 64'd3);
        cycle(3'b101, A123, DABC, 1'b0, 1'b0);
        check_val("hold_rel0", {61'b0, obs_rdy}, 64'b001);
        cycle(3'b101, A123, DABC, 1'b0, 1'b0);
        check_val("hold_rel2", {61'b0, obs_rdy}, 64'b100);
        check_val("hold_cnt2", {48'b0, cnt}, 64'd5);

        // saturation of the narrow counter
        for (int i = 0; i < 20; i++) cycle(3'b111, A123, DABC, 1'b0, 1'b0);
        check_val("sat_cnt4", {60'b0, cnt_s}, 64'd15);
        check_val("sat_cnt16", {48'b0, cnt}, 64'd25);

        // reset while a request is valid
        cycle(3'b010, A123, DABC, 1'b0, 1'b1);
        check_val("midrst_ready", {61'b0, obs_rdy}, 64'd0);
        check_val("midrst_we", {63'b0, rf_we}, 64'd0);
        check_val("midrst_addr", {59'b0, rf_addr}, 64'd0);
        check_val("midrst_data", {32'b0, rf_data}, 64'd0);
        check_val("midrst_cnt", {48'b0, cnt}, 64'd0);
        check_val("midrst_cnt4", {60'b0, cnt_s}, 64'd0);
        cycle(3'b010, A123, DABC, 1'b0, 1'b0);
        check_val("midrst_pending", {61'b0, obs_rdy}, 64'b010);

        // randomized traffic; sources hold their request until it is taken
        for (int k = 0; k < 3; k++) begin
            src_v[k] = 1'b0; src_a[k] = '0; src_d[k] = '0;
        end
        for (int n = 0; n < 2000; n++) begin
            for (int k = 0; k < 3; k++) begin
                if (!src_v[k] && ($urandom % 3 != 0)) begin
                    src_v[k] = 1'b1;
                    src_a[k] = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
                    src_d[k] = $urandom;
                end
                rv[k] = src_v[k];
                ra[k*5 +: 5] = src_a[k];
                rd[k*32 +: 32] = src_d[k];
            end
            rh = ($urandom % 10 == 0);
            rr = ($urandom % 50 == 0);
            cycle(rv, ra, rd, rh, rr);
            if (m_g >= 0) src_v[m_g] = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
